// File: rtl/fifoc2cs.sv
// fifoc2cs: reads one framed command (55 AA CMD LEN DATA.. CSUM) from FIFO C and publishes it.
// Latency: one byte per 2 cycles; results and pulses appear on the cycle DONE is entered.
// Backpressure: reads only while FIFO C is non-empty; an empty FIFO aborts after TIMEOUT idle cycles.
module fifoc2cs #(
  parameter int MAX_LEN = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fs_fifoc2cs,
  output logic                   fd_fifoc2cs,
  input  logic                   fifoc_empty,
  output logic                   fifoc_rd_en,
  input  logic [7:0]             fifoc_dout,
  output logic [7:0]             cmd_code,
  output logic [7:0]             cmd_len,
  output logic [8*MAX_LEN-1:0]   cmd_data,
  output logic                   cmd_vld,
  output logic                   err_csum,
  output logic                   err_len,
  output logic                   err_tmo
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR0, S_HDR1, S_CMD, S_LEN, S_DATA, S_CSUM, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic                 pend_q;
  logic [TW-1:0]        tmo_q;
  logic [7:0]           csum_q, idx_q, code_q, len_q;
  logic [8*MAX_LEN-1:0] buf_q;
  logic [7:0]           cmd_code_q, cmd_len_q;
  logic [8*MAX_LEN-1:0] cmd_data_q;
  logic                 cmd_vld_q, err_csum_q, err_len_q, err_tmo_q;

  logic       rd_state, byte_vld, tmo_hit, live;
  logic [7:0] byte_dat;

  // The byte requested last cycle is on fifoc_dout now; pend_q doubles as its valid flag.
  assign rd_state = (state_q != S_IDLE) && (state_q != S_DONE);
  assign live     = rd_state && fs_fifoc2cs;
  assign byte_vld = pend_q;
  assign byte_dat = fifoc_dout;
  assign tmo_hit  = rd_state && !byte_vld && (tmo_q == TW'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state: abort on fs drop beats timeout, which beats byte handling
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (fs_fifoc2cs) state_d = S_HDR0;
      S_DONE: if (!fs_fifoc2cs) state_d = S_IDLE;
      default: begin
        if (!fs_fifoc2cs) begin
          state_d = S_IDLE;
        end else if (tmo_hit) begin
          state_d = S_DONE;
        end else if (byte_vld) begin
          case (state_q)
            S_HDR0: if (byte_dat == 8'h55) state_d = S_HDR1;
            S_HDR1: begin
              if (byte_dat == 8'hAA)      state_d = S_CMD;
              else if (byte_dat != 8'h55) state_d = S_HDR0;
            end
            S_CMD: state_d = S_LEN;
            S_LEN: begin
              if (byte_dat > 8'(MAX_LEN)) state_d = S_DONE;
              else if (byte_dat == 8'h00) state_d = S_CSUM;
              else                        state_d = S_DATA;
            end
            S_DATA: if (idx_q == len_q - 8'd1) state_d = S_CSUM;
            S_CSUM: state_d = S_DONE;
            default: state_d = state_q;
          endcase
        end
      end
    endcase
  end

  // Outputs: no read while a byte is in flight, on the timeout cycle or during an abort
  always_comb begin
    fifoc_rd_en = !rst && live && !fifoc_empty && !pend_q && !tmo_hit;
    fd_fifoc2cs = (state_q == S_DONE);
  end

  // Datapath: fetch handshake, timeout, checksum, payload assembly and publication
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q     <= 1'b0;
      tmo_q      <= '0;
      csum_q     <= '0;
      idx_q      <= '0;
      code_q     <= '0;
      len_q      <= '0;
      buf_q      <= '0;
      cmd_code_q <= '0;
      cmd_len_q  <= '0;
      cmd_data_q <= '0;
      cmd_vld_q  <= 1'b0;
      err_csum_q <= 1'b0;
      err_len_q  <= 1'b0;
      err_tmo_q  <= 1'b0;
    end else begin
      cmd_vld_q  <= 1'b0;
      err_csum_q <= 1'b0;
      err_len_q  <= 1'b0;
      err_tmo_q  <= 1'b0;
      pend_q     <= fifoc_rd_en;
      tmo_q      <= (rd_state && !byte_vld) ? tmo_q + TW'(1) : '0;

      if (state_q == S_IDLE && fs_fifoc2cs) begin
        csum_q <= '0;
        idx_q  <= '0;
        buf_q  <= '0;
      end

      if (live && tmo_hit) err_tmo_q <= 1'b1;

      if (live && byte_vld) begin
        case (state_q)
          S_CMD: begin
            code_q <= byte_dat;
            csum_q <= byte_dat;
          end
          S_LEN: begin
            len_q  <= byte_dat;
            csum_q <= csum_q ^ byte_dat;
            if (byte_dat > 8'(MAX_LEN)) err_len_q <= 1'b1;
          end
          S_DATA: begin
            for (int i = 0; i < MAX_LEN; i++) begin
              if (idx_q == 8'(i)) buf_q[8*i +: 8] <= byte_dat;
            end
            csum_q <= csum_q ^ byte_dat;
            idx_q  <= idx_q + 8'd1;
          end
          S_CSUM: begin
            if (byte_dat == csum_q) begin
              cmd_code_q <= code_q;
              cmd_len_q  <= len_q;
              cmd_data_q <= buf_q;
              cmd_vld_q  <= 1'b1;
            end else begin
              err_csum_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign cmd_code = cmd_code_q;
  assign cmd_len  = cmd_len_q;
  assign cmd_data = cmd_data_q;
  assign cmd_vld  = cmd_vld_q;
  assign err_csum = err_csum_q;
  assign err_len  = err_len_q;
  assign err_tmo  = err_tmo_q;

endmodule
